// File: rtl/online_pkg.sv
// Shared definitions for the online-arithmetic blocks: word-length helper,
// borrow-save digit encodings and the on-the-fly converter state encoding.
package online_pkg;

  // Online word length in radix-2 digit positions for a given stage count.
  function automatic int wl_of(input int stage);
    return 2 * stage;
  endfunction

  // Borrow-save digit {p,n}; 2'b00 and 2'b11 both mean zero.
  localparam logic [1:0] DIG_POS = 2'b10;
  localparam logic [1:0] DIG_NEG = 2'b01;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } otf_state_t;

endpackage

// File: rtl/otf_converter_if.sv
// Digit-stream input and completed-word output handshakes of the converter.
interface otf_converter_if #(
  parameter int Stage = 6
);
  import online_pkg::*;

  localparam int WL = wl_of(Stage);

  logic          din_valid;
  logic          din_ready;
  logic [1:0]    din;
  logic          dout_valid;
  logic          dout_ready;
  logic [WL:0]   dout;

  // master: digit producer and word consumer; slave: the converter.
  modport master (
    output din_valid, din, dout_ready,
    input  din_ready, dout_valid, dout
  );

  modport slave (
    input  din_valid, din, dout_ready,
    output din_ready, dout_valid, dout
  );

endinterface

// File: rtl/otf_update.sv
// Combinational on-the-fly conversion step: next Q/QM from the current pair
// and one signed digit, truncated to W bits.
module otf_update
  import online_pkg::*;
#(
  parameter int W = 13
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next,
  output logic [W-1:0] qm_next
);

  logic [W-1:0] q_sh;
  logic [W-1:0] qm_sh;

  assign q_sh  = q << 1;
  assign qm_sh = qm << 1;

  always_comb begin
    // Zero digit (either encoding) is the default.
    q_next  = q_sh;
    qm_next = qm_sh | W'(1);
    case (digit)
      DIG_POS: begin
        q_next  = q_sh | W'(1);
        qm_next = q_sh;
      end
      DIG_NEG: begin
        q_next  = qm_sh | W'(1);
        qm_next = qm_sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/otf_converter.sv
// On-the-fly converter: assembles an MSD-first redundant digit stream into a
// two's-complement word, presenting it with a valid/ready handshake.
module otf_converter
  import online_pkg::*;
#(
  parameter int Stage = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  otf_converter_if.slave   bus,
  output logic             busy
);

  localparam int WL = wl_of(Stage);
  localparam int CW = $clog2(WL);
  localparam logic [CW-1:0] LAST_CNT = CW'(WL - 1);

  otf_state_t     state_reg;
  logic [WL:0]    q_reg;
  logic [WL:0]    qm_reg;
  logic [WL:0]    q_next;
  logic [WL:0]    qm_next;
  logic [WL:0]    dout_reg;
  logic [CW-1:0]  cnt_reg;
  logic           din_ready_reg;
  logic           dout_valid_reg;

  otf_update #(
    .W (WL + 1)
  ) u_update (
    .q       (q_reg),
    .qm      (qm_reg),
    .digit   (bus.din),
    .q_next  (q_next),
    .qm_next (qm_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ACCUM;
      q_reg          <= '0;
      qm_reg         <= '1;
      cnt_reg        <= '0;
      dout_reg       <= '0;
      din_ready_reg  <= 1'b1;
      dout_valid_reg <= 1'b0;
    end else if (flush) begin
      // Abort wins over any digit transfer or output handshake this cycle.
      state_reg      <= ACCUM;
      q_reg          <= '0;
      qm_reg         <= '1;
      cnt_reg        <= '0;
      din_ready_reg  <= 1'b1;
      dout_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (bus.din_valid) begin
            q_reg  <= q_next;
            qm_reg <= qm_next;
            if (cnt_reg == LAST_CNT) begin
              state_reg      <= DONE;
              dout_reg       <= q_next;
              cnt_reg        <= '0;
              din_ready_reg  <= 1'b0;
              dout_valid_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        DONE: begin
          if (bus.dout_ready) begin
            state_reg      <= ACCUM;
            q_reg          <= '0;
            qm_reg         <= '1;
            cnt_reg        <= '0;
            din_ready_reg  <= 1'b1;
            dout_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign bus.din_ready  = din_ready_reg;
  assign bus.dout_valid = dout_valid_reg;
  assign bus.dout       = dout_reg;
  // Digits accepted only in ACCUM, so a nonzero count there means mid-word.
  assign busy = din_ready_reg && (cnt_reg != '0);

endmodule

// File: tb/tb_otf_converter.sv
// Self-checking bench for otf_converter: directed words plus random words and
// stalls, compared against an arithmetic digit-sum reference.
module tb_otf_converter;
  localparam int Stage = 6;
  localparam int WL    = 12;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;
  int   checks = 0;
  int   fails  = 0;

  otf_converter_if #(.Stage(Stage)) bus ();

  otf_converter #(.Stage(Stage)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Digit values: +1, 0, -1; the value 2 stands for a zero sent as 2'b11.
  function automatic logic [1:0] enc(input int v);
    logic [1:0] e;
    if (v == 1)       e = 2'b10;
    else if (v == -1) e = 2'b01;
    else if (v == 2)  e = 2'b11;
    else              e = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    return e;
  endfunction

  // Reference: Q = sum d_i * 2^(WL-i), wrapped to WL+1 bits.
  function automatic logic [WL:0] model(input int d[WL]);
    longint acc = 0;
    for (int i = 0; i < WL; i++) acc = acc * 2 + ((d[i] == 2) ? 0 : d[i]);
    return acc[WL:0];
  endfunction

  task automatic send_digits(input int d[WL], input int n, input bit stall);
    for (int k = 0; k < n; k++) begin
      while (stall && $urandom_range(0, 2) == 0) begin
        bus.din_valid = 1'b0;
        bus.din       = 2'($urandom);
        @(posedge clk); @(negedge clk);
      end
      bus.din_valid = 1'b1;
      bus.din       = enc(d[k]);
      @(posedge clk); @(negedge clk);
      bus.din_valid = 1'b0;
    end
  endtask

  task automatic finish_word(input string tag, input logic [WL:0] exp, input int hold);
    bit stable = 1'b1;
    check({tag, "_valid_latency"}, 32'(bus.dout_valid), 32'd1);
    check({tag, "_din_ready_done"}, 32'(bus.din_ready), 32'd0);
    check({tag, "_dout"}, 32'(bus.dout), 32'(exp));
    $display("word %s: dout=%h expected=%h", tag, bus.dout, exp);
    for (int h = 0; h < hold; h++) begin
      bus.dout_ready = 1'b0;
      bus.din_valid  = 1'($urandom);
      bus.din        = 2'($urandom);
      @(posedge clk); @(negedge clk);
      if (bus.dout !== exp || bus.dout_valid !== 1'b1 || bus.din_ready !== 1'b0) stable = 1'b0;
    end
    check({tag, "_stable"}, 32'(stable), 32'd1);
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.dout_ready = 1'b0;
    check({tag, "_release"}, {30'd0, bus.dout_valid, bus.din_ready}, 32'b01);
  endtask

  initial begin
    int d[WL];
    rst = 1'b1;
    flush = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = 2'b00;
    bus.dout_ready = 1'b0;
    @(negedge clk);
    check("reset_outputs", {28'd0, bus.dout_valid, bus.din_ready, busy, 1'b0}, 32'b0100);
    check("reset_dout", 32'(bus.dout), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All +1, no stalls.
    foreach (d[i]) d[i] = 1;
    send_digits(d, 1, 1'b0);
    check("busy_after_first", 32'(busy), 32'd1);
    send_digits(d, WL - 1, 1'b0);
    finish_word("all_pos", 13'h0FFF, 1);

    foreach (d[i]) d[i] = -1;
    send_digits(d, WL, 1'b0);
    finish_word("all_neg", 13'h1001, 0);

    foreach (d[i]) d[i] = 0;
    d[0] = 1; d[1] = -1;
    send_digits(d, WL, 1'b0);
    finish_word("pos_neg", 13'h0400, 0);

    d[0] = -1; d[1] = 1;
    send_digits(d, WL, 1'b0);
    finish_word("neg_pos", 13'h1C00, 0);

    // Random din_valid gaps and a five-cycle output stall.
    foreach (d[i]) d[i] = 1;
    send_digits(d, WL, 1'b1);
    finish_word("stalled", 13'h0FFF, 5);

    // Flush after 5 digits; the digit presented with flush is discarded.
    send_digits(d, 5, 1'b0);
    flush = 1'b1;
    bus.din_valid = 1'b1;
    bus.din = 2'b10;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    bus.din_valid = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    foreach (d[i]) d[i] = 2;
    send_digits(d, WL, 1'b0);
    finish_word("flush_zeros11", 13'h0000, 0);

    // Flush while a completed word waits.
    foreach (d[i]) d[i] = -1;
    send_digits(d, WL, 1'b0);
    flush = 1'b1;
    bus.dout_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    bus.dout_ready = 1'b0;
    check("flush_in_done", {30'd0, bus.dout_valid, bus.din_ready}, 32'b01);

    // Reset mid-word after 7 digits.
    foreach (d[i]) d[i] = 1;
    send_digits(d, 7, 1'b0);
    rst = 1'b1;
    #1;
    check("midword_rst", {28'd0, bus.dout_valid, bus.din_ready, busy, 1'b0}, 32'b0100);
    check("midword_rst_dout", 32'(bus.dout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_digits(d, WL, 1'b0);
    finish_word("after_rst", 13'h0FFF, 0);

    // Random words against the reference.
    for (int w = 0; w < 20; w++) begin
      foreach (d[i]) d[i] = $urandom_range(0, 2) - 1;
      send_digits(d, WL, 1'b1);
      finish_word($sformatf("rand%0d", w), model(d), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/otf_converter.md
OTF_CONVERTER -- requirements
Module: otf_converter

Interface
REQ-001 SHALL have parameter Stage, default 6, setting the online word size in radix-2 digit positions as WL = 2*Stage.
REQ-002 SHALL derive localparam WL = 2*Stage; it is not overridable.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous abort of the current word.
REQ-006 SHALL have port din_valid, input, 1 bit: din carries a digit this cycle.
REQ-007 SHALL have port din_ready, output, 1 bit: block accepts a digit this cycle.
REQ-008 SHALL have port din, input, 2 bits, borrow-save signed digit {p,n}, value p-n: 10=+1, 01=-1, 00 and 11 both 0.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout holds a completed word.
REQ-010 SHALL have port dout_ready, input, 1 bit: consumer accepts dout.
REQ-011 SHALL have port dout, output, WL+1 bits: two's-complement integer Q with Q*2^-WL = sum of d_i*2^-i, i = 1..WL, MSD first.
REQ-012 SHALL have port busy, output, 1 bit: high when at least one digit of the current word has been accepted and dout_valid is low.

Function
REQ-013 SHALL consume the MSD-first redundant digit stream produced by the upstream online redundant-adder stage, one digit per accepted transfer.
REQ-014 SHALL implement a two-state FSM: ACCUM (din_ready=1, dout_valid=0) and DONE (din_ready=0, dout_valid=1).
REQ-015 SHALL count a digit transfer only when din_valid & din_ready.
REQ-016 SHALL hold registers Q and QM, each WL+1 bits, with invariant QM = Q-1, initial values Q=0 and QM=all ones.
REQ-017 SHALL, on each transfer, apply the following update, truncating to WL+1 bits: d=+1 -> Q=2Q+1, QM=2Q; d=0 -> Q=2Q, QM=2QM+1; d=-1 -> Q=2QM+1, QM=2QM.
REQ-018 SHALL keep a digit counter 0..WL-1; when the transfer of digit WL occurs, SHALL enter DONE on the next edge with dout=Q, so latency is 1 cycle from the last digit to dout_valid.
REQ-019 SHALL hold dout and dout_valid stable in DONE until dout_ready=1.
REQ-020 SHALL, on a dout_valid & dout_ready edge, return to ACCUM with Q=0, QM=all ones and counter=0; the first digit of the next word is accepted no earlier than the following cycle.
REQ-021 SHALL, when flush=1, take priority over any transfer or dout handshake in the same cycle: next state ACCUM, Q=0, QM=all ones, counter=0, and the digit presented that cycle is discarded.
REQ-022 SHALL leave all state unchanged in ACCUM when din_valid=0.
REQ-023 SHALL ignore din and din_valid in DONE.

Reset
REQ-024 SHALL, on rst=1 (asynchronous, active-high), force state ACCUM, Q=0, QM=all ones, counter=0, dout=0, dout_valid=0, din_ready=1 and busy=0.
REQ-025 SHALL discard a partially assembled word when rst is asserted mid-word; the next word starts fresh after rst is released.

Structure
REQ-026 SHALL place WL derivation helpers, the digit encoding constants (DIG_POS=10, DIG_NEG=01) and the FSM state encoding in shared package online_pkg.
REQ-027 SHALL implement the Q/QM next-value selection of REQ-017 in one combinational sub-module, otf_update, parameterised by width.

Verification (Stage=6, WL=12)
REQ-028 SHALL verify that 12 digits of +1 with no stalls -> dout=0x0FFF, dout_valid asserted one cycle after the 12th transfer.
REQ-029 SHALL verify that 12 digits of -1 -> dout=0x1001 (-4095).
REQ-030 SHALL verify that digits +1, -1, then 10 zeros -> dout=0x0400, and that digits -1, +1, then 10 zeros -> dout=0x1C00.
REQ-031 SHALL verify that din_valid toggled randomly plus dout_ready held low 5 cycles -> the same result as the stall-free run, dout stable throughout, din_ready=0 during DONE.
REQ-032 SHALL verify that flush after 5 digits, then 12 zero digits -> dout=0x0000; and that encoding 11 is treated as 0.
REQ-033 SHALL verify that rst pulsed mid-word (after 7 digits) -> outputs at reset values immediately, and the following 12 x +1 word -> dout=0x0FFF.
